board_display: RTL and testbench

BOARD_DISPLAY -- requirements
Module: board_display

---
 rtl/board_display.sv | 147 ++++++++++++++
 tb/tb_board_display.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/board_display.sv
// board_display: four-digit multiplexed hex display of the low bytes of the
// pipeline PC and a selected register, plus a debounced single-step button
// that produces one clock-wide pulse per accepted press.
module board_display #(
  parameter int unsigned REFRESH_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] reg_in,
  input  logic        step_btn,
  output logic        step_pulse,
  output logic [3:0]  anode,
  output logic [6:0]  cathode
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  // Active-low seven-segment codes, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // ---------------- display multiplexing ----------------
  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    snap_pc_q, snap_pc_d;
  logic [7:0]    snap_reg_q, snap_reg_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    cathode_q, cathode_d;
  logic [3:0]    nib;

  // Next refresh/digit/snapshot state; anode and cathode are decoded from the
  // next index and next snapshot so both outputs switch on the same edge.
  always_comb begin
    refresh_d  = refresh_q + 1'b1;
    idx_d      = idx_q;
    snap_pc_d  = snap_pc_q;
    snap_reg_d = snap_reg_q;
    if (refresh_q == REF_LAST) begin
      refresh_d = '0;
      idx_d     = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        snap_pc_d  = pc_in[7:0];
        snap_reg_d = reg_in[7:0];
      end
    end
    case (idx_d)
      2'd0:    nib = snap_reg_d[3:0];
      2'd1:    nib = snap_reg_d[7:4];
      2'd2:    nib = snap_pc_d[3:0];
      default: nib = snap_pc_d[7:4];
    endcase
    anode_d   = ~(4'b0001 << idx_d);
    cathode_d = hex7(nib);
  end

  // Display state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_q  <= '0;
      idx_q      <= '0;
      snap_pc_q  <= '0;
      snap_reg_q <= '0;
      anode_q    <= 4'b1110;
      cathode_q  <= 7'b1000000;
    end else begin
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      snap_pc_q  <= snap_pc_d;
      snap_reg_q <= snap_reg_d;
      anode_q    <= anode_d;
      cathode_q  <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

  // ---------------- step button ----------------
  logic          sync1_q, sync2_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_lvl_q, db_lvl_d;
  logic          db_prev_q;
  logic          pulse_q, pulse_d;

  // Stable counter runs only while the synchronized level disagrees with the
  // accepted level; any return to the accepted level restarts it.
  always_comb begin
    db_cnt_d = db_cnt_q;
    db_lvl_d = db_lvl_q;
    if (sync2_q == db_lvl_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_lvl_d = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    pulse_d = db_lvl_q & ~db_prev_q;
  end

  // Synchronizer, debouncer and pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      db_lvl_q  <= 1'b0;
      db_prev_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      sync1_q   <= step_btn;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      db_lvl_q  <= db_lvl_d;
      db_prev_q <= db_lvl_q;
      pulse_q   <= pulse_d;
    end
  end

  assign step_pulse = pulse_q;

endmodule

// File: tb/tb_board_display.sv
// Directed testbench for board_display with REFRESH_DIV=4, DEBOUNCE_CYCLES=3.
module tb_board_display;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] reg_in;
  logic        step_btn;
  logic        step_pulse;
  logic [3:0]  anode;
  logic [6:0]  cathode;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  board_display #(
    .REFRESH_DIV    (4),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pc_in     (pc_in),
    .reg_in    (reg_in),
    .step_btn  (step_btn),
    .step_pulse(step_pulse),
    .anode     (anode),
    .cathode   (cathode)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Press for 20 cycles and expect exactly one pulse, visible after the 6th edge.
  task automatic press_20(input string tag);
    int unsigned pulses;
    pulses = 0;
    step_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_eq(tag, {31'd0, step_pulse}, {31'd0, (i == 6)});
      if (step_pulse) pulses++;
    end
    check_eq({tag, "_count"}, pulses, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_anode"}, {28'd0, anode}, 32'hE);
    check_eq({tag, "_cath"}, {25'd0, cathode}, {25'd0, 7'b1000000});
    check_eq({tag, "_pulse"}, {31'd0, step_pulse}, 0);
  endtask

  initial begin
    logic [7:0] ep, er;
    logic [3:0] nib, ea;
    int unsigned d, pulses;

    reset    = 1'b1;
    pc_in    = 32'h0000001C;
    reg_in   = 32'h000000A5;
    step_btn = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("rst");

    // Display: frame 0 blank snapshot, then 1C/A5, pc changes to FF mid-frame.
    for (int k = 0; k < 64; k++) begin
      if (k < 16) begin
        ep = 8'h00; er = 8'h00;
      end else if (k < 48) begin
        ep = 8'h1C; er = 8'hA5;
      end else begin
        ep = 8'hFF; er = 8'hA5;
      end
      d = (k / 4) % 4;
      case (d)
        0: nib = er[3:0];
        1: nib = er[7:4];
        2: nib = ep[3:0];
        default: nib = ep[7:4];
      endcase
      ea = 4'b1111;
      ea[d] = 1'b0;
      check_eq("anode", {28'd0, anode}, {28'd0, ea});
      check_eq("cathode", {25'd0, cathode}, {25'd0, seg_tbl[nib]});
      check_eq("idle_pulse", {31'd0, step_pulse}, 0);
      if (k == 36) pc_in = 32'h000000FF;
      tick();
    end

    // Short glitches: 2 cycles high, 3 low, five times.
    pulses = 0;
    for (int r = 0; r < 5; r++) begin
      step_btn = 1'b1;
      tick(); if (step_pulse) pulses++;
      tick(); if (step_pulse) pulses++;
      step_btn = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick(); if (step_pulse) pulses++;
      end
    end
    for (int j = 0; j < 6; j++) begin
      tick(); if (step_pulse) pulses++;
    end
    check_eq("glitch_pulses", pulses, 0);

    press_20("press1");

    // Release: no pulse on the falling debounced edge.
    step_btn = 1'b0;
    pulses = 0;
    for (int j = 0; j < 10; j++) begin
      tick(); if (step_pulse) pulses++;
    end
    check_eq("release_pulses", pulses, 0);

    press_20("press2");
    step_btn = 1'b0;
    for (int j = 0; j < 10; j++) tick();

    // Reset during a debounce count with a 2-cycle press.
    step_btn = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    step_btn = 1'b0;
    tick();
    reset = 1'b0;
    check_reset_outputs("rst_mid");
    pulses = 0;
    for (int j = 0; j < 10; j++) begin
      tick(); if (step_pulse) pulses++;
    end
    check_eq("rst_mid_pulses", pulses, 0);

    // Reset on the edge that would otherwise raise a pending pulse.
    step_btn = 1'b1;
    for (int j = 0; j < 5; j++) tick();
    reset = 1'b1;
    step_btn = 1'b0;
    tick();
    reset = 1'b0;
    check_reset_outputs("rst_pend");
    pulses = 0;
    for (int j = 0; j < 10; j++) begin
      tick(); if (step_pulse) pulses++;
    end
    check_eq("rst_pend_pulses", pulses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
